// File: rtl/cim_pkg.sv
// Shared CIM definitions: default geometry of the psum drain path and the drain FSM state type.
package cim_pkg;

  localparam int unsigned CIM_NUM_SUB_MACROS = 4;
  localparam int unsigned CIM_NUM_COLS       = 32;
  localparam int unsigned CIM_ODATA_WIDTH    = 21;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_ACK      = 2'd2,
    ST_WAIT_CLR = 2'd3
  } drain_state_e;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cim_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
module cim_rr_arbiter
  import cim_pkg::*;
#(
  parameter int unsigned N     = CIM_NUM_SUB_MACROS,
  parameter int unsigned SEL_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             valid,
  output logic [SEL_W-1:0] grant,
  output logic             grant_vld
);

  int               w_idx;
  logic [SEL_W-1:0] w_sel;

  // Walk offsets from farthest to nearest so the nearest set request is written last and wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    w_idx     = 0;
    w_sel     = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      w_idx = (int'(ptr) + k) % int'(N);
      w_sel = w_idx[SEL_W-1:0];
      if (valid && req[w_sel]) begin
        grant     = w_sel;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cim_psum_drain_arb.sv
// Drains full psum buffers of several sub-macros, one granted sub-macro at a time, as a column stream.
module cim_psum_drain_arb
  import cim_pkg::*;
#(
  parameter  int unsigned NUM_SUB_MACROS = CIM_NUM_SUB_MACROS,
  parameter  int unsigned NUM_COLS       = CIM_NUM_COLS,
  parameter  int unsigned ODATA_WIDTH    = CIM_ODATA_WIDTH,
  localparam int unsigned SEL_W          = clog2_min1(NUM_SUB_MACROS),
  localparam int unsigned COL_W          = clog2_min1(NUM_COLS)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         drain_en,
  input  logic [NUM_SUB_MACROS*NUM_COLS*ODATA_WIDTH-1:0] psum_buff_out,
  input  logic [NUM_SUB_MACROS-1:0]                    psum_data_ready,
  output logic [NUM_SUB_MACROS-1:0]                    psum_ack,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [ODATA_WIDTH-1:0]                       out_data,
  output logic [SEL_W-1:0]                             out_macro_id,
  output logic [COL_W-1:0]                             out_col_id,
  output logic                                         out_last,
  output logic                                         busy,
  output logic                                         proto_err,
  output drain_state_e                                 dbg_state
);

  localparam int unsigned BUS_W = NUM_SUB_MACROS * NUM_COLS * ODATA_WIDTH;
  localparam int unsigned IDX_W = clog2_min1(BUS_W);

  drain_state_e     r_state,   w_state_nxt;
  logic [SEL_W-1:0] r_grant,   w_grant_nxt;
  logic [SEL_W-1:0] r_rr_ptr,  w_rr_ptr_nxt;
  logic [COL_W-1:0] r_col,     w_col_nxt;
  logic             r_proto_err, w_proto_err_nxt;

  logic [SEL_W-1:0] w_arb_grant;
  logic             w_arb_vld;
  logic             w_col_last;
  logic             w_xfer;
  logic [IDX_W-1:0] w_base;

  cim_rr_arbiter #(
    .N     (NUM_SUB_MACROS),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .req       (psum_data_ready),
    .ptr       (r_rr_ptr),
    .valid     (drain_en),
    .grant     (w_arb_grant),
    .grant_vld (w_arb_vld)
  );

  // Stream handshake: a word moves only in a cycle where out_valid and out_ready are both high;
  // out_valid never depends on out_ready, and the word holds until it is taken.
  assign w_col_last = (r_col == COL_W'(NUM_COLS - 1));
  assign w_xfer     = out_valid && out_ready;
  assign w_base     = IDX_W'((int'(r_grant) * int'(NUM_COLS) + int'(r_col)) * int'(ODATA_WIDTH));

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_col_nxt       = r_col;
    w_proto_err_nxt = r_proto_err;
    psum_ack        = '0;
    out_valid       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_arb_vld) begin
          w_state_nxt  = ST_STREAM;
          w_grant_nxt  = w_arb_grant;
          w_col_nxt    = '0;
          w_rr_ptr_nxt = (w_arb_grant == SEL_W'(NUM_SUB_MACROS - 1)) ? '0
                                                                     : w_arb_grant + SEL_W'(1);
        end
      end
      ST_STREAM: begin
        out_valid = 1'b1;
        // A buffer that stops claiming full mid-drain is a producer bug; finish anyway and flag it.
        if (!psum_data_ready[r_grant]) w_proto_err_nxt = 1'b1;
        if (w_xfer) begin
          if (w_col_last) begin
            w_state_nxt = ST_ACK;
            w_col_nxt   = '0;
          end else begin
            w_col_nxt = r_col + COL_W'(1);
          end
        end
      end
      ST_ACK: begin
        psum_ack[r_grant] = 1'b1;
        w_state_nxt       = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        if (!psum_data_ready[r_grant]) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_col       <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_col       <= w_col_nxt;
      r_proto_err <= w_proto_err_nxt;
    end
  end

  assign out_data     = psum_buff_out[w_base +: ODATA_WIDTH];
  assign out_macro_id = r_grant;
  assign out_col_id   = r_col;
  assign out_last     = (r_state == ST_STREAM) && w_col_last;
  assign busy         = (r_state != ST_IDLE);
  assign proto_err    = r_proto_err;
  assign dbg_state    = r_state;

endmodule
